uart_tx_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_counter.sv | 44 ++++
 rtl/uart_tx_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter control slice: FSM state encoding,
// datapath output-mux selects and the frame data width.
package uart_pkg;

    localparam int FRAME_BITS = 8;

    localparam logic [1:0] OUT_START = 2'b00;
    localparam logic [1:0] OUT_DATA  = 2'b01;
    localparam logic [1:0] OUT_IDLE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    function automatic logic [1:0] sel_of(tx_state_e s);
        logic [1:0] r;
        r = OUT_IDLE;
        unique case (s)
            IDLE:  r = OUT_IDLE;
            START: r = OUT_START;
            DATA:  r = OUT_DATA;
            STOP:  r = OUT_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// clear holds it at zero; preload_one restarts a bit already one cycle in.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    localparam int BC_W = $clog2(CLKS_PER_BIT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            preload_one,
    output logic            bit_end,
    output logic [BC_W-1:0] bc
);

    localparam logic [BC_W-1:0] BC_MAX = BC_W'(CLKS_PER_BIT - 1);

    logic [BC_W-1:0] bc_d;
    logic [BC_W-1:0] bc_q;

    assign bc      = bc_q;
    assign bit_end = (bc_q == BC_MAX);

    always_comb begin
        bc_d = bc_q + BC_W'(1);
        if (clear) begin
            bc_d = '0;
        end else if (preload_one) begin
            bc_d = BC_W'(1);
        end else if (bit_end) begin
            bc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bc_q <= '0;
        end else begin
            bc_q <= bc_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start/data/stop timing, byte handshake and
// strobes for the shift-register / down-counter / mux datapath.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    input  logic       end_count,
    output logic       load_data,
    output logic       shift,
    output logic       count,
    output logic       set_count,
    output logic [1:0] out_sel
);

    localparam int         BC_W       = $clog2(CLKS_PER_BIT);
    localparam logic [3:0] BIDX_LIMIT = 4'(FRAME_BITS);
    localparam logic       SIDX_LAST  = 1'(STOP_BITS - 1);

    tx_state_e       state_d;
    tx_state_e       state_q;
    logic            sidx_d;
    logic            sidx_q;
    logic [3:0]      bidx_d;
    logic [3:0]      bidx_q;

    logic            bit_end;
    logic [BC_W-1:0] bc;
    logic            bc_clear;
    logic            preload_one;
    logic            last_stop;
    logic            frame_end;
    logic            handshake;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .reset      (reset),
        .clear      (bc_clear),
        .preload_one(preload_one),
        .bit_end    (bit_end),
        .bc         (bc)
    );

    assign last_stop = (sidx_q == SIDX_LAST);
    assign frame_end = (state_q == STOP) && bit_end && last_stop;

    // end_count lands one cycle into the stop bit, hence the preload of one
    assign bc_clear    = (state_q == IDLE);
    assign preload_one = (state_q == DATA) && end_count;

    assign tx_ready  = !reset && ((state_q == IDLE) || frame_end);
    assign handshake = tx_ready && tx_valid;
    assign load_data = handshake;
    assign set_count = reset || handshake;

    assign tx_busy = !reset && (state_q != IDLE);
    assign tx_done = !reset && frame_end;
    assign shift   = !reset && (state_q == DATA) && bit_end;
    assign count   = shift;
    assign out_sel = reset ? OUT_IDLE : sel_of(state_q);

    always_comb begin
        state_d = state_q;
        sidx_d  = sidx_q;
        bidx_d  = bidx_q;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = START;
                    sidx_d  = 1'b0;
                    bidx_d  = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bidx_d = bidx_q + 4'd1;
                end
                // a ninth count pulse means end_count never came
                if (end_count) begin
                    state_d = STOP;
                end else if (bit_end && (bidx_q == BIDX_LIMIT)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        sidx_d  = 1'b0;
                        bidx_d  = '0;
                        state_d = handshake ? START : IDLE;
                    end else begin
                        sidx_d = sidx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sidx_q  <= 1'b0;
            bidx_q  <= '0;
        end else begin
            state_q <= state_d;
            sidx_q  <= sidx_d;
            bidx_q  <= bidx_d;
        end
    end

    a_idle_bc_zero: assert property (
        @(posedge clk) disable iff (reset)
        (state_q == IDLE) |-> (bc == '0)
    );

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl: two instances (1 and 2 stop bits), a
// small datapath model closing the end_count loop, and a frame-level reference.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int NI  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid  [NI];
    logic       end_count [NI];
    logic       tx_ready  [NI];
    logic       tx_busy   [NI];
    logic       tx_done   [NI];
    logic       load_data [NI];
    logic       shift     [NI];
    logic       count     [NI];
    logic       set_count [NI];
    logic [1:0] out_sel   [NI];

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]),
        .end_count(end_count[0]), .load_data(load_data[0]), .shift(shift[0]),
        .count(count[0]), .set_count(set_count[0]), .out_sel(out_sel[0])
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]),
        .end_count(end_count[1]), .load_data(load_data[1]), .shift(shift[1]),
        .count(count[1]), .set_count(set_count[1]), .out_sel(out_sel[1])
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    logic [7:0] data    [NI];
    logic [7:0] qbuf    [NI][8];
    int         qh      [NI];
    int         qn      [NI];
    bit         gl_en;

    logic [7:0] sr      [NI];
    int         cnt     [NI];
    logic       txd     [NI];
    logic       ec_nxt  [NI];
    logic       txd_nxt [NI];

    bit         in_frame [NI];
    int         t        [NI];
    logic [7:0] fbyte    [NI];
    bit         fault    [NI];
    bit         nfault   [NI];
    logic       exp_txd  [NI];
    bit         hs       [NI];
    int         t0       [NI];
    int         n_cnt    [NI];
    logic [1:0] prev_sel [NI];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        if (qn[i] < 8) begin
            qbuf[i][(qh[i] + qn[i]) % 8] = b;
            qn[i]++;
        end
    endtask

    task automatic req_drive();
        for (int i = 0; i < NI; i++) begin
            bit glitch;
            if (hs[i] && qn[i] > 0) begin
                qh[i] = (qh[i] + 1) % 8;
                qn[i]--;
            end
            glitch = gl_en && in_frame[i] && t[i] >= 2 && t[i] <= 20
                     && ($urandom_range(0, 2) == 0);
            tx_valid[i] = (qn[i] > 0) || glitch;
            data[i] = (qn[i] > 0) ? qbuf[i][qh[i]] : 8'($urandom);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            int         len;
            int         dend;
            logic       rdy;
            logic       busy;
            logic       done;
            logic       ld;
            logic       setc;
            logic       sh;
            logic       line;
            logic [1:0] sel;

            dend = fault[i] ? 10 * CPB : 9 * CPB + 1;
            len  = (fault[i] ? 10 + (i + 1) : 9 + (i + 1)) * CPB;
            rdy  = 1'b0;
            busy = 1'b0;
            done = 1'b0;
            sh   = 1'b0;
            sel  = OUT_IDLE;
            line = 1'b1;
            if (!reset && !in_frame[i]) begin
                rdy = 1'b1;
            end else if (!reset) begin
                busy = 1'b1;
                done = (t[i] == len);
                rdy  = done;
                if (t[i] <= CPB) sel = OUT_START;
                else if (t[i] <= dend) sel = OUT_DATA;
                sh = (t[i] > CPB) && (t[i] <= dend) && (t[i] % CPB == 0);
                if (t[i] <= CPB) line = 1'b0;
                else if (t[i] <= 9 * CPB) line = fbyte[i][(t[i] - CPB - 1) / CPB];
            end
            ld   = rdy && tx_valid[i];
            setc = reset || ld;

            chk($sformatf("ctl%0d", i),
                32'({tx_ready[i], tx_busy[i], tx_done[i], load_data[i],
                     set_count[i], shift[i], count[i], out_sel[i]}),
                32'({rdy, busy, done, ld, setc, sh, sh, sel}));
            chk($sformatf("txd%0d", i), 32'(txd[i]), 32'(exp_txd[i]));

            if (out_sel[i] == OUT_START && prev_sel[i] != OUT_START) begin
                t0[i]    = cyc;
                n_cnt[i] = 0;
            end
            if (count[i]) n_cnt[i]++;
            if (tx_done[i] && in_frame[i] && !reset) begin
                chk($sformatf("len%0d", i), 32'(cyc - t0[i] + 1), 32'(len));
                chk($sformatf("npulse%0d", i), 32'(n_cnt[i]),
                    32'(fault[i] ? 9 : 8));
            end
            prev_sel[i] = out_sel[i];
            exp_txd[i]  = line;

            // datapath model driven by the observed strobes
            case (out_sel[i])
                OUT_START: txd_nxt[i] = 1'b0;
                OUT_DATA:  txd_nxt[i] = sr[i][0];
                default:   txd_nxt[i] = 1'b1;
            endcase
            ec_nxt[i] = 1'b0;
            if (count[i]) begin
                ec_nxt[i] = (cnt[i] == 1) && !fault[i];
                cnt[i]--;
            end
            if (set_count[i]) cnt[i] = 8;
            if (load_data[i]) sr[i] = data[i];
            else if (shift[i]) sr[i] = {1'b1, sr[i][7:1]};

            hs[i] = ld;
            if (reset) begin
                in_frame[i] = 1'b0;
            end else if (ld) begin
                in_frame[i] = 1'b1;
                t[i]        = 1;
                fbyte[i]    = data[i];
                fault[i]    = nfault[i];
            end else if (in_frame[i]) begin
                if (t[i] == len) in_frame[i] = 1'b0;
                else t[i]++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            end_count[i] = ec_nxt[i];
            txd[i]       = txd_nxt[i];
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            req_drive();
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        gl_en = 1'b0;
        for (int i = 0; i < NI; i++) begin
            tx_valid[i]  = 1'b0;
            end_count[i] = 1'b0;
            data[i]      = '0;
            qh[i]        = 0;
            qn[i]        = 0;
            sr[i]        = '1;
            cnt[i]       = 8;
            txd[i]       = 1'b1;
            exp_txd[i]   = 1'b1;
            in_frame[i]  = 1'b0;
            t[i]         = 0;
            fbyte[i]     = '0;
            fault[i]     = 1'b0;
            nfault[i]    = 1'b0;
            hs[i]        = 1'b0;
            t0[i]        = 0;
            n_cnt[i]     = 0;
            prev_sel[i]  = OUT_IDLE;
        end
        @(posedge clk);
        #1;
        run(2);
        reset = 1'b0;

        push(0, 8'hA5);
        push(1, 8'h3C);
        run(50);

        push(0, 8'h00);
        push(0, 8'hFF);
        push(1, 8'h00);
        push(1, 8'hFF);
        run(100);

        push(0, 8'h55);
        for (int k = 0; k < 60; k++) begin
            if (in_frame[0] && t[0] == 4 * CPB + 2) break;
            run(1);
        end
        chk("reach_bit3", 32'(in_frame[0] && t[0] == 4 * CPB + 2), 32'd1);
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        push(0, 8'h81);
        run(60);

        gl_en = 1'b1;
        push(0, 8'h5A);
        push(1, 8'hC3);
        run(50);
        gl_en = 1'b0;

        nfault[0] = 1'b1;
        nfault[1] = 1'b1;
        push(0, 8'h96);
        push(1, 8'h69);
        run(5);
        nfault[0] = 1'b0;
        nfault[1] = 1'b0;
        run(60);

        repeat (2500) begin
            for (int i = 0; i < NI; i++) begin
                if (qn[i] < 3 && $urandom_range(0, 39) == 0) push(i, 8'($urandom));
                nfault[i] = ($urandom_range(0, 7) == 0);
            end
            gl_en = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 499) == 0);
            run(1);
        end
        reset = 1'b0;
        gl_en = 1'b0;
        run(150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
